// File: rtl/qeciphy_crc_pkg.sv
// Shared CRC constants and step functions for the QECIPHY link layer.
// The TX framing logic uses the same step functions as the CRC engine.
package qeciphy_crc_pkg;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;
  localparam logic [7:0]  CRC8_POLY  = 8'h07;
  localparam logic [7:0]  CRC8_SEED  = 8'h00;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FULL} crc_state_e;

  function automatic logic [15:0] crc16_step1(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

  // Whole 64-bit beat, MSB first.
  function automatic logic [15:0] crc16_step64(input logic [15:0] crc, input logic [63:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 63; i >= 0; i--) c = crc16_step1(c, data[i]);
    return c;
  endfunction

  function automatic logic [7:0] crc8_step8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? CRC8_POLY : 8'h00);
    return c;
  endfunction
endpackage

// File: rtl/qeciphy_crc16_group_acc.sv
// One CRC16 group accumulator: reseed has priority over a data step.
module qeciphy_crc16_group_acc
  import qeciphy_crc_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              seed_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [15:0]       crc_o
);
  logic [15:0] crc_nxt;

  // Bitwise so any byte-multiple beat width works; DATA_W=64 matches crc16_step64.
  always_comb begin
    crc_nxt = crc_o;
    for (int i = DATA_W - 1; i >= 0; i--) crc_nxt = crc16_step1(crc_nxt, data_i[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || seed_i) crc_o <= CRC16_SEED;
    else if (en_i)       crc_o <= crc_nxt;
  end
endmodule

// File: rtl/qeciphy_crc_engine.sv
// Multi-group CRC16 engine with CRC8 tag protection; generate (TX) or
// check (RX, CHECK_EN=1) mode. Results publish one cycle after the CRC beat.
module qeciphy_crc_engine
  import qeciphy_crc_pkg::*;
#(
  parameter int NUM_GROUPS      = 3,
  parameter int WORDS_PER_GROUP = 2,
  parameter int DATA_W          = 64,
  parameter int CHECK_EN        = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    faw_boundary_i,
  input  logic                    crc_boundary_i,
  input  logic                    tvalid_i,
  input  logic [DATA_W-1:0]       tdata_i,
  output logic [NUM_GROUPS*16-1:0] crc_o,
  output logic [7:0]              crcvw_o,
  output logic                    crc_valid_o,
  output logic [NUM_GROUPS-1:0]   crc_err_o,
  output logic                    crcvw_err_o,
  output logic                    short_frame_o,
  output logic                    overrun_o
);
  localparam int N  = NUM_GROUPS * WORDS_PER_GROUP;
  localparam int KW = $clog2(N + 1);

  crc_state_e                   state_q;
  logic [KW-1:0]                k_q;
  logic                         ovr_q;
  logic [NUM_GROUPS-1:0][15:0]  acc;
  logic [NUM_GROUPS-1:0][15:0]  crc_pub;
  logic [NUM_GROUPS-1:0]        crc_err_nxt;
  logic [7:0]                   crcvw_nxt;
  logic [KW-1:0]                grp_idx;
  logic                         boundary, close, data_beat;

  assign boundary  = faw_boundary_i | crc_boundary_i;
  assign close     = crc_boundary_i & ~faw_boundary_i;
  assign data_beat = tvalid_i & ~boundary & (state_q != ST_IDLE);
  assign grp_idx   = k_q / KW'(WORDS_PER_GROUP);
  assign crc_pub   = (state_q == ST_IDLE) ? {NUM_GROUPS{CRC16_SEED}} : acc;
  assign crcvw_nxt = crc8_step8(CRC8_SEED, tdata_i[15:8]);

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    qeciphy_crc16_group_acc #(.DATA_W(DATA_W)) u_acc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .seed_i (boundary),
      .en_i   (data_beat && state_q == ST_ACCUM && grp_idx == KW'(g)),
      .data_i (tdata_i),
      .crc_o  (acc[g])
    );
    assign crc_err_nxt[g] = tdata_i[16*g+16 +: 16] != crc_pub[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      ovr_q         <= 1'b0;
      crc_o         <= {NUM_GROUPS{CRC16_SEED}};
      crcvw_o       <= 8'h00;
      crc_valid_o   <= 1'b0;
      crc_err_o     <= '0;
      crcvw_err_o   <= 1'b0;
      short_frame_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      crc_valid_o <= 1'b0;
      if (boundary) begin
        state_q <= ST_ACCUM;
        k_q     <= '0;
        ovr_q   <= 1'b0;
        if (close) begin
          crc_o         <= crc_pub;
          crcvw_o       <= crcvw_nxt;
          crc_valid_o   <= 1'b1;
          short_frame_o <= (state_q == ST_ACCUM);
          overrun_o     <= ovr_q;
          crc_err_o     <= (CHECK_EN != 0) ? crc_err_nxt : '0;
          crcvw_err_o   <= (CHECK_EN != 0) && (crcvw_nxt != tdata_i[7:0]);
        end
      end else if (data_beat) begin
        // Beats past N are counted only as an overrun; accumulators stay frozen.
        if (state_q == ST_FULL) ovr_q <= 1'b1;
        else begin
          k_q <= k_q + KW'(1);
          if (k_q == KW'(N - 1)) state_q <= ST_FULL;
        end
      end
    end
  end
endmodule

// File: tb/tb_qeciphy_crc_engine.sv
// Directed bench: generate-mode and check-mode engines share one stimulus stream.
module tb_qeciphy_crc_engine;
  logic        clk = 1'b0;
  logic        rst, faw, crcb, tv;
  logic [63:0] td;

  logic [47:0] g_crc, c_crc;
  logic [7:0]  g_vw, c_vw;
  logic        g_val, c_val, g_vwe, c_vwe, g_sh, c_sh, g_ov, c_ov;
  logic [2:0]  g_err, c_err;

  int total = 0;
  int bad   = 0;
  logic [63:0]  pat [8];
  logic [47:0]  last_exp;

  always #5 clk = ~clk;

  qeciphy_crc_engine #(.NUM_GROUPS(3), .WORDS_PER_GROUP(2), .DATA_W(64), .CHECK_EN(0)) u_gen (
    .clk_i(clk), .rst_i(rst), .faw_boundary_i(faw), .crc_boundary_i(crcb), .tvalid_i(tv),
    .tdata_i(td), .crc_o(g_crc), .crcvw_o(g_vw), .crc_valid_o(g_val), .crc_err_o(g_err),
    .crcvw_err_o(g_vwe), .short_frame_o(g_sh), .overrun_o(g_ov));

  qeciphy_crc_engine #(.NUM_GROUPS(3), .WORDS_PER_GROUP(2), .DATA_W(64), .CHECK_EN(1)) u_chk (
    .clk_i(clk), .rst_i(rst), .faw_boundary_i(faw), .crc_boundary_i(crcb), .tvalid_i(tv),
    .tdata_i(td), .crc_o(c_crc), .crcvw_o(c_vw), .crc_valid_o(c_val), .crc_err_o(c_err),
    .crcvw_err_o(c_vwe), .short_frame_o(c_sh), .overrun_o(c_ov));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Byte-at-a-time reference CRC16 (0x1021), MSB first.
  function automatic logic [15:0] m16(input logic [15:0] c, input logic [63:0] d);
    for (int b = 7; b >= 0; b--) begin
      c = c ^ {d[8*b +: 8], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] m8(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // Expected {g2,g1,g0} after n data beats of pat[]; beats past 6 are ignored.
  function automatic logic [47:0] model(input int n);
    logic [15:0] e [3];
    for (int g = 0; g < 3; g++) e[g] = 16'hFFFF;
    for (int i = 0; i < n && i < 6; i++) e[i/2] = m16(e[i/2], pat[i]);
    return {e[2], e[1], e[0]};
  endfunction

  task automatic cyc(input logic f, input logic c, input logic v, input logic [63:0] d);
    faw = f; crcb = c; tv = v; td = d;
    @(posedge clk); #1;
    faw = 1'b0; crcb = 1'b0; tv = 1'b0; td = {$urandom, $urandom};
  endtask

  task automatic beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1, pat[i]);
      if (gaps) repeat (1 + i % 3) cyc(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
    end
  endtask

  // CRC beat carrying correct received fields XOR flip; checks both engines.
  task automatic close_frame(input string tag, input int n, input logic [63:0] flip,
                             input logic [2:0] xerr, input logic xvwe);
    logic [47:0] e;
    logic [7:0]  t;
    e = model(n);
    t = 8'h30 + 8'(n);
    cyc(1'b0, 1'b1, 1'b0, {e, t, m8(t)} ^ flip);
    chk({tag, ".valid"}, {62'd0, g_val, c_val}, 64'h3);
    chk({tag, ".crc"}, {16'd0, g_crc}, {16'd0, e});
    chk({tag, ".crc_chk"}, {16'd0, c_crc}, {16'd0, e});
    chk({tag, ".vw"}, {56'd0, g_vw}, {56'd0, m8(t)});
    chk({tag, ".short"}, {63'd0, g_sh}, {63'd0, n < 6});
    chk({tag, ".ovr"}, {63'd0, g_ov}, {63'd0, n > 6});
    chk({tag, ".gen_err"}, {60'd0, g_err, g_vwe}, 64'd0);
    chk({tag, ".chk_err"}, {60'd0, c_err, c_vwe}, {60'd0, xerr, xvwe});
    last_exp = e;
  endtask

  initial begin
    pat[0] = 64'h3132333435363738; pat[1] = 64'h3837363534333231;
    pat[2] = 64'h0102030405060708; pat[3] = 64'hDEADBEEFCAFEF00D;
    pat[4] = 64'h0000000000000000; pat[5] = 64'hFFFFFFFFFFFFFFFF;
    pat[6] = 64'hA5A5A5A5A5A5A5A5; pat[7] = 64'h5A5A5A5A5A5A5A5A;
    rst = 1'b1; faw = 1'b0; crcb = 1'b0; tv = 1'b0; td = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.crc", {16'd0, g_crc}, {16'd0, 48'hFFFF_FFFF_FFFF});
    chk("rst.flags", {56'd0, g_val, g_sh, g_ov, g_vwe, g_err, 1'b0}, 64'd0);
    chk("rst.vw", {56'd0, c_vw}, 64'd0);
    rst = 1'b0;

    // Data in IDLE is ignored; CRC beat in IDLE publishes seeds, tag 0x01 -> 0x07.
    beats(2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, {48'hFFFF_FFFF_FFFF, 8'h01, 8'h07});
    chk("idle.valid", {63'd0, g_val}, 64'd1);
    chk("idle.crc", {16'd0, g_crc}, {16'd0, 48'hFFFF_FFFF_FFFF});
    chk("idle.vw", {56'd0, g_vw}, 64'h07);
    chk("idle.short", {63'd0, g_sh}, 64'd0);
    chk("idle.chk_err", {60'd0, c_err, c_vwe}, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk("pulse.drop", {62'd0, g_val, c_val}, 64'd0);

    beats(6, 1'b0);  close_frame("full", 6, 64'd0, 3'b000, 1'b0);
    beats(6, 1'b1);  close_frame("gaps", 6, 64'd0, 3'b000, 1'b0);
    beats(6, 1'b0);  close_frame("bit20", 6, 64'd1 << 20, 3'b001, 1'b0);
    beats(6, 1'b0);  close_frame("bit0", 6, 64'd1, 3'b000, 1'b1);
    beats(4, 1'b0);  close_frame("short4", 4, 64'd0, 3'b000, 1'b0);
    beats(8, 1'b0);  close_frame("ovr8", 8, 64'd0, 3'b000, 1'b0);
    beats(6, 1'b0);  close_frame("ovr_clr", 6, 64'd0, 3'b000, 1'b0);
    beats(1, 1'b0);  close_frame("single", 1, 64'd0, 3'b000, 1'b0);
    close_frame("empty", 0, 64'd0, 3'b000, 1'b0);

    // Frame-alignment restart mid-frame discards the partial beats.
    cyc(1'b0, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
    cyc(1'b0, 1'b0, 1'b1, 64'h5555_6666_7777_8888);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    chk("faw.novalid", {62'd0, g_val, c_val}, 64'd0);
    beats(6, 1'b0);  close_frame("after_faw", 6, 64'd0, 3'b000, 1'b0);

    // faw together with crc: no publish, previous results hold.
    cyc(1'b0, 1'b0, 1'b1, 64'h9999_AAAA_BBBB_CCCC);
    cyc(1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    chk("fawcrc.novalid", {62'd0, g_val, c_val}, 64'd0);
    chk("fawcrc.hold", {16'd0, g_crc}, {16'd0, last_exp});
    beats(6, 1'b0);  close_frame("after_fawcrc", 6, 64'd0, 3'b000, 1'b0);

    // Reset mid-frame: outputs return to reset values, engine back in IDLE.
    beats(3, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, pat[3]);
    rst = 1'b0;
    chk("midrst.crc", {16'd0, g_crc}, {16'd0, 48'hFFFF_FFFF_FFFF});
    chk("midrst.flags", {60'd0, g_val, g_sh, g_ov, c_vwe}, 64'd0);
    beats(2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, {48'hFFFF_FFFF_FFFF, 8'h01, 8'h07});
    chk("midrst.idle_crc", {16'd0, c_crc}, {16'd0, 48'hFFFF_FFFF_FFFF});
    chk("midrst.idle_short", {62'd0, g_sh, g_val}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/qeciphy_crc_engine.md
# qeciphy_crc_engine

Parametrised multi-group CRC engine for the QECIPHY link layer. It generalises the fixed three-pair CRC compute block to NUM_GROUPS CRC16 groups of WORDS_PER_GROUP data beats each, tolerates gaps via tvalid_i, and optionally checks received CRCs in the CRC beat. It sits between the lane word aligner and the RX/TX framing logic: TX uses it in generate mode, RX in check mode.

## Interface
- NUM_GROUPS, 3, number of CRC16 groups per frame (1..3 for DATA_W=64)
- WORDS_PER_GROUP, 2, data beats covered by each group's CRC16 (1..8)
- DATA_W, 64, beat width; must satisfy NUM_GROUPS*16+16 <= DATA_W, multiple of 8
- CHECK_EN, 0, 1 = compare computed CRCs against CRC-beat fields and drive error flags
- clk_i  in  1  single clock domain
- rst_i  in  1  reset; synchronous, active-high
- faw_boundary_i  in  1  frame-alignment boundary: restart frame, discard partial CRCs
- crc_boundary_i  in  1  CRC beat: close frame, publish results, restart
- tvalid_i  in  1  qualifies tdata_i as a data beat (ignored on boundary cycles)
- tdata_i  in  DATA_W  beat data
- crc_o  out  NUM_GROUPS*16  computed CRC16 per group; group g at [16g+15:16g]
- crcvw_o  out  8  CRC8 of tag byte tdata_i[15:8] of the CRC beat
- crc_valid_o  out  1  one-cycle pulse: crc_o/crcvw_o/flags updated
- crc_err_o  out  NUM_GROUPS  per-group received-vs-computed mismatch (CHECK_EN=1, else 0)
- crcvw_err_o  out  1  tag CRC8 mismatch (CHECK_EN=1, else 0)
- short_frame_o  out  1  fewer than N=NUM_GROUPS*WORDS_PER_GROUP data beats in frame
- overrun_o  out  1  more than N data beats in frame (excess ignored)

## Operation
- CRC16-IBM3740: poly 0x1021, seed 0xFFFF, no reflection, no xorout; 64-bit beat processed MSB-first in one cycle. CRC8-SMBUS: poly 0x07, seed 0x00, no reflection/xorout.
- States: IDLE (after reset; data beats ignored), ACCUM (beat count k < N), FULL (k = N). Any boundary in any state -> ACCUM, k=0, all group accumulators reseeded to 0xFFFF at that edge.
- Data beat = tvalid_i & ~faw_boundary_i & ~crc_boundary_i in ACCUM/FULL. In ACCUM, beat k updates group k / WORDS_PER_GROUP only; k increments; k = N-1 -> FULL. In FULL a data beat sets a sticky overrun bit, accumulators unchanged.
- crc_boundary_i (without faw): snapshot accumulators to crc_o, compute crcvw_o from tdata_i[15:8], pulse crc_valid_o, short_frame_o = (k<N) & ~IDLE, overrun_o = sticky bit, then clear sticky bit and reseed. In IDLE: crc_o = 0xFFFF per group published, short_frame_o = 0.
- CHECK_EN=1 CRC-beat layout: received CRC16 for group g at tdata_i[16g+31:16g+16], tag at [15:8], received CRC8 at [7:0]; crc_err_o[g] = mismatch, crcvw_err_o = mismatch.
- faw_boundary_i alone, or with crc_boundary_i: faw wins; reseed, clear k and sticky bit, no crc_valid_o pulse, outputs hold.

## Timing
- Reset: crc_o all 0xFFFF, crcvw_o 0x00, crc_valid_o/crc_err_o/crcvw_err_o/short_frame_o/overrun_o 0, state IDLE. Reset overrides all inputs that cycle; reset mid-frame discards the frame.
- CRC beat sampled at edge T -> crc_valid_o high during cycle T+1 only; crc_o, crcvw_o and flags valid from T+1 and held until next CRC beat.
- Data beat at edge T contributes to a frame whose CRC beat is at T+1 or later (back-to-back allowed); zero-gap boundaries allowed (empty frame -> seeds published, short_frame_o=1).
- Throughput: one beat per cycle, no backpressure output.

## Structure
- Package qeciphy_crc_pkg: CRC16_POLY/SEED, CRC8_POLY/SEED constants, state enum, functions crc16_step64 and crc8_step8 (shared with TX framing).
- Sub-module qeciphy_crc16_group_acc: one accumulator (seed load, enable, step); generate-looped NUM_GROUPS times.

## Test plan
- Reset then crc_boundary_i with tag 0x01 -> T+1: crc_valid_o=1, crc_o all 0xFFFF, crcvw_o=0x07, short_frame_o=0.
- Boundary, 6 beats ASCII "12345678"-padded per golden model, crc beat -> crc_o matches model per group; single-beat group with 0x3132333435363738 vs model; flags 0.
- Same frame with tvalid_i gaps of 1-3 cycles -> identical crc_o to gap-free run.
- CHECK_EN=1, corrupt bit 20 (group 0 field) in CRC beat -> crc_err_o=3'b001, crcvw_err_o=0; corrupt bit 0 -> crcvw_err_o=1.
- 4 data beats then crc beat -> short_frame_o=1; 8 beats -> overrun_o=1, crc_o equals 6-beat result.
- faw_boundary_i mid-frame, and faw+crc simultaneously -> no crc_valid_o pulse, next frame CRCs unaffected by discarded beats.
